noise_gate: RTL

// Sample-rate noise gate placed directly upstream of the distortion clipper. It keeps idle pickup hiss

---
 rtl/fx_pkg.sv | 15 +
 rtl/envelope_follower.sv | 38 +++
 rtl/noise_gate.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the effects chain: gate states and the Q1.15 gain format.
package fx_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

  localparam int unsigned GAIN_UNITY = 32768;
  localparam int unsigned GAIN_FRAC  = 15;

endpackage

// File: rtl/envelope_follower.sv
// Peak envelope follower: saturating magnitude, exponential decay, updated on in_valid only.
module envelope_follower #(
  parameter int unsigned width       = 16,
  parameter int unsigned DECAY_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_signal,
  output logic        [width-1:0] env_n,
  output logic        [width-1:0] env
);

  logic [width-1:0] mag;
  logic [width-1:0] decayed;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    mag = unsigned'(in_signal);
    if (in_signal == {1'b1, {(width-1){1'b0}}})
      mag = {1'b0, {(width-1){1'b1}}};
    else if (in_signal[width-1])
      mag = unsigned'(-in_signal);
  end

  always_comb begin
    decayed = env - (env >> DECAY_SHIFT);
    env_n   = (mag > decayed) ? mag : decayed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      env <= '0;
    else if (in_valid)
      env <= env_n;
  end

endmodule

// File: rtl/noise_gate.sv
// Noise gate ahead of the clipper: envelope-driven 5-state gate FSM with gain ramps,
// followed by a rounding Q1.15 multiply. Two-cycle latency from in_valid to out_valid.
module noise_gate
  import fx_pkg::*;
#(
  parameter int unsigned width        = 16,
  parameter int unsigned DECAY_SHIFT  = 8,
  parameter int unsigned ATTACK_STEP  = 2048,
  parameter int unsigned RELEASE_STEP = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_signal,
  input  logic        [width-1:0] open_thresh,
  input  logic        [width-1:0] close_thresh,
  input  logic        [15:0]      hold_samples,
  output logic                    out_valid,
  output logic signed [width-1:0] out_signal,
  output logic                    gate_open
);

  localparam logic [16:0] UNITY = 17'(GAIN_UNITY);
  localparam logic signed [width+16:0] ROUND = (width+17)'(1) <<< (GAIN_FRAC - 1);

  gate_state_t state, state_n;
  logic [15:0] gain, gain_n;
  logic [15:0] hold_cnt, hold_n;
  logic        gate_open_n;

  logic [width-1:0] env_n;
  logic [width-1:0] env;
  logic             above_open, below_close;

  logic [16:0] gain_up_raw, hold_inc;
  logic [15:0] gain_up, gain_dn;
  logic        up_full, dn_empty;

  logic signed [width-1:0]  s1;
  logic                     v1;
  logic signed [width+16:0] prod;

  envelope_follower #(
    .width      (width),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_signal(in_signal),
    .env_n    (env_n),
    .env      (env)
  );

  always_comb begin
    above_open  = env_n >= open_thresh;
    below_close = env_n < close_thresh;
    gain_up_raw = {1'b0, gain} + 17'(ATTACK_STEP);
    up_full     = gain_up_raw >= UNITY;
    gain_up     = up_full ? UNITY[15:0] : gain_up_raw[15:0];
    dn_empty    = {1'b0, gain} <= 17'(RELEASE_STEP);
    gain_dn     = dn_empty ? '0 : gain - 16'(RELEASE_STEP);
    hold_inc    = {1'b0, hold_cnt} + 17'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
    end else if (in_valid) begin
      state     <= state_n;
      gain      <= gain_n;
      hold_cnt  <= hold_n;
      gate_open <= gate_open_n;
    end
  end

  // Gain follows the post-transition state, so the entering sample already ramps.
  always_comb begin
    state_n = state;
    gain_n  = gain;
    hold_n  = hold_cnt;
    if (!enable) begin
      state_n = OPEN;
      gain_n  = UNITY[15:0];
    end else begin
      unique case (state)
        CLOSED: begin
          gain_n = '0;
          if (above_open) begin
            state_n = up_full ? OPEN : ATTACK;
            gain_n  = gain_up;
          end
        end
        ATTACK, RELEASE: begin
          if (above_open || (state == ATTACK && !below_close)) begin
            state_n = up_full ? OPEN : ATTACK;
            gain_n  = gain_up;
          end else begin
            state_n = dn_empty ? CLOSED : RELEASE;
            gain_n  = gain_dn;
          end
        end
        OPEN: begin
          gain_n = UNITY[15:0];
          if (!above_open && below_close) begin
            state_n = HOLD;
            hold_n  = '0;
          end
        end
        HOLD: begin
          gain_n = UNITY[15:0];
          if (above_open) begin
            state_n = OPEN;
          end else begin
            hold_n = hold_inc[15:0];
            if (hold_inc >= {1'b0, hold_samples}) begin
              state_n = RELEASE;
              gain_n  = gain_dn;
            end
          end
        end
        default: begin
          state_n = CLOSED;
          gain_n  = '0;
        end
      endcase
    end
  end

  always_comb begin
    gate_open_n = state_n inside {ATTACK, OPEN, HOLD};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid)
        s1 <= in_signal;
    end
  end

  assign prod = (width+17)'(s1) * (width+17)'($signed({1'b0, gain}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_signal <= '0;
    end else begin
      out_valid <= v1;
      if (v1)
        out_signal <= width'((prod + ROUND) >>> GAIN_FRAC);
    end
  end

endmodule
